// File: rtl/h_mux8way_arb.sv
// Purpose : 8-source round-robin merge into one registered stream, each beat tagged with its source index.
// Latency : 1 cycle from the accepting edge to out_*; sustains 1 beat/cycle while out_ready=1.
// Backpressure: out_ready=0 while holding a beat freezes the output register and ptr, and holds in_ready at 0.
//
// Ports:
//   clk, rst_n              single clock, asynchronous active-low reset
//   in_valid[7:0]           source i offers a beat
//   in_data[8*WIDTH-1:0]    source i payload at [i*WIDTH +: WIDTH]
//   in_ready[7:0]           one-hot (or zero) grant, combinational from in_valid/out_ready
//   out_valid/out_ready     output handshake
//   out_data, out_sel       held payload and the index of the source that supplied it
module h_mux8way_arb #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           in_valid,
    input  logic [8*WIDTH-1:0]   in_data,
    output logic [7:0]           in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [2:0]           out_sel
);

    logic [2:0]       ptr;
    logic             load_en;
    logic             grant_vld;
    logic [2:0]       grant_idx;
    logic [2:0]       scan_idx;
    logic [WIDTH-1:0] grant_data;

    // The output register can take a new beat when it is empty or being drained this cycle.
    assign load_en = !out_valid || out_ready;

    // Round-robin scan: walk offsets from farthest to nearest so the candidate
    // closest to ptr (lowest offset) is the one left standing.
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = ptr;
        grant_data = '0;
        scan_idx   = ptr;
        for (int k = 7; k >= 0; k--) begin
            scan_idx = ptr + 3'(k);
            if (in_valid[scan_idx]) begin
                grant_vld  = 1'b1;
                grant_idx  = scan_idx;
                grant_data = in_data[int'(scan_idx)*WIDTH +: WIDTH];
            end
        end
    end

    // Gated by rst_n so no source sees its beat taken while the block is held in reset.
    always_comb begin
        in_ready = 8'h00;
        if (rst_n && load_en && grant_vld) begin
            in_ready = 8'h01 << grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 3'd0;
            ptr       <= 3'd0;
        end else if (load_en) begin
            if (grant_vld) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_sel   <= grant_idx;
                ptr       <= grant_idx + 3'd1;
            end else begin
                // Idle drain: payload/tag keep their last values, ptr stays put.
                out_valid <= 1'b0;
            end
        end
    end

endmodule
